mem_path_router: RTL and testbench

- Downstream counterpart of the address translator: consumes the translated request (physical address plus cached flag) from the CPU's memory stage.
- Steers each request to either the cache port or the uncached port, runs the SRAM-like req/addr_ok/data_ok handshake on the selected port, and returns the response to the CPU.
- Exactly one request is in flight at a time; the CPU-side response is registered.
- Per-path access counters and a sticky protocol-error flag are provided for debug.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_path_router.sv | 134 +++++++++++++
 tb/tb_mem_path_router.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the memory path router
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } route_state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_path_router.sv
// rtl/mem_path_router.sv - steers one translated request at a time to the cache or uncached port
module mem_path_router
  import mem_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cpu_req,
  input  logic             cpu_wr,
  input  logic [1:0]       cpu_size,
  input  logic [31:0]      cpu_paddr,
  input  logic             cpu_cached,
  input  logic [31:0]      cpu_wdata,
  input  logic [3:0]       cpu_wstrb,
  output logic             cpu_addr_ok,
  output logic             cpu_data_ok,
  output logic [31:0]      cpu_rdata,
  output logic             c_req,
  output logic             c_wr,
  output logic [1:0]       c_size,
  output logic [31:0]      c_addr,
  output logic [31:0]      c_wdata,
  output logic [3:0]       c_wstrb,
  input  logic             c_addr_ok,
  input  logic             c_data_ok,
  input  logic [31:0]      c_rdata,
  output logic             u_req,
  output logic             u_wr,
  output logic [1:0]       u_size,
  output logic [31:0]      u_addr,
  output logic [31:0]      u_wdata,
  output logic [3:0]       u_wstrb,
  input  logic             u_addr_ok,
  input  logic             u_data_ok,
  input  logic [31:0]      u_rdata,
  output logic [CNT_W-1:0] cached_cnt,
  output logic [CNT_W-1:0] uncached_cnt,
  output logic             proto_err
);

  route_state_e state_q, state_d;
  mem_req_t     req_q;
  logic         cached_q;
  logic         capture;
  logic         busy;
  logic         c_sel, u_sel;
  logic         sel_addr_ok, sel_data_ok;
  logic [31:0]  sel_rdata;

  assign sel_addr_ok = cached_q ? c_addr_ok : u_addr_ok;
  assign sel_data_ok = cached_q ? c_data_ok : u_data_ok;
  assign sel_rdata   = cached_q ? c_rdata   : u_rdata;
  assign busy        = (state_q == ISSUE) || (state_q == WAIT);

  always_comb begin
    state_d     = state_q;
    cpu_addr_ok = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_addr_ok = cpu_req;
        if (cpu_req) state_d = ISSUE;
      end
      ISSUE: begin
        if (sel_addr_ok) begin
          if (sel_data_ok) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (sel_data_ok) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Only the selected port sees the request; the idle port is driven to all-zero.
  assign c_sel   = (state_q == ISSUE) && cached_q;
  assign u_sel   = (state_q == ISSUE) && !cached_q;
  assign c_req   = c_sel;
  assign c_wr    = c_sel & req_q.wr;
  assign c_size  = c_sel ? req_q.size  : 2'b0;
  assign c_addr  = c_sel ? req_q.addr  : 32'b0;
  assign c_wdata = c_sel ? req_q.wdata : 32'b0;
  assign c_wstrb = c_sel ? req_q.wstrb : 4'b0;
  assign u_req   = u_sel;
  assign u_wr    = u_sel & req_q.wr;
  assign u_size  = u_sel ? req_q.size  : 2'b0;
  assign u_addr  = u_sel ? req_q.addr  : 32'b0;
  assign u_wdata = u_sel ? req_q.wdata : 32'b0;
  assign u_wstrb = u_sel ? req_q.wstrb : 4'b0;

  assign cpu_data_ok = (state_q == RESP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cached_q     <= 1'b0;
      cpu_rdata    <= 32'b0;
      cached_cnt   <= '0;
      uncached_cnt <= '0;
      proto_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cpu_req) begin
        req_q.wr    <= cpu_wr;
        req_q.size  <= cpu_size;
        req_q.addr  <= cpu_paddr;
        req_q.wdata <= cpu_wdata;
        req_q.wstrb <= cpu_wstrb;
        cached_q    <= cpu_cached;
      end
      if (capture) cpu_rdata <= req_q.wr ? 32'b0 : sel_rdata;
      if (state_q == RESP) begin
        if (cached_q) cached_cnt   <= cached_cnt + CNT_W'(1);
        else          uncached_cnt <= uncached_cnt + CNT_W'(1);
      end
      // A response outside a transaction, or from the port we did not drive, is a protocol fault.
      if ((c_data_ok && (!busy || !cached_q)) || (u_data_ok && (!busy || cached_q)))
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_path_router.sv
// tb/tb_mem_path_router.sv - directed self-checking bench for mem_path_router
module tb_mem_path_router;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_wr, cpu_cached;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_paddr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        c_req, c_wr, u_req, u_wr;
  logic [1:0]  c_size, u_size;
  logic [31:0] c_addr, c_wdata, u_addr, u_wdata;
  logic [3:0]  c_wstrb, u_wstrb;
  logic        c_addr_ok, c_data_ok, u_addr_ok, u_data_ok;
  logic [31:0] c_rdata, u_rdata;
  logic [3:0]  cached_cnt, uncached_cnt;
  logic        proto_err;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [3:0]  exp_c  = 4'd0;
  logic [3:0]  exp_u  = 4'd0;

  always #5 clk = ~clk;

  mem_path_router #(.CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_paddr(cpu_paddr),
    .cpu_cached(cpu_cached), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .c_req(c_req), .c_wr(c_wr), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_wstrb(c_wstrb), .c_addr_ok(c_addr_ok), .c_data_ok(c_data_ok), .c_rdata(c_rdata),
    .u_req(u_req), .u_wr(u_wr), .u_size(u_size), .u_addr(u_addr), .u_wdata(u_wdata),
    .u_wstrb(u_wstrb), .u_addr_ok(u_addr_ok), .u_data_ok(u_data_ok), .u_rdata(u_rdata),
    .cached_cnt(cached_cnt), .uncached_cnt(uncached_cnt), .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ports;
    c_addr_ok = 1'b0; c_data_ok = 1'b0;
    u_addr_ok = 1'b0; u_data_ok = 1'b0;
  endtask

  task automatic reset_dut;
    resetn = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    exp_c  = 4'd0;
    exp_u  = 4'd0;
  endtask

  // Starts in an IDLE cycle, ends in the IDLE cycle after RESP.
  task automatic do_txn(input logic cached, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int stall, input logic same, input logic [31:0] rdata,
                        input logic spur);
    logic [31:0] exp_rd;
    exp_rd = wr ? 32'h0 : rdata;
    cpu_req = 1'b1; cpu_cached = cached; cpu_wr = wr; cpu_size = size;
    cpu_paddr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    #1;
    check("addr_ok_idle", cpu_addr_ok, 1);
    tick;
    // Keep cpu_req high with scrambled fields: nothing may be accepted or leak through.
    cpu_cached = ~cached; cpu_wr = ~wr; cpu_paddr = ~addr; cpu_wdata = ~wdata;
    cpu_wstrb = ~wstrb; cpu_size = ~size;
    for (int k = 0; k <= stall; k++) begin
      if (cached) begin
        c_addr_ok = (k == stall); c_data_ok = (k == stall) && same; c_rdata = rdata;
      end else begin
        u_addr_ok = (k == stall); u_data_ok = (k == stall) && same; u_rdata = rdata;
      end
      #1;
      check("sel_req",   cached ? c_req   : u_req,   1);
      check("other_req", cached ? u_req   : c_req,   0);
      check("other_addr", cached ? u_addr : c_addr,  0);
      check("sel_addr",  cached ? c_addr  : u_addr,  addr);
      check("sel_wdata", cached ? c_wdata : u_wdata, wdata);
      check("sel_wstrb", cached ? c_wstrb : u_wstrb, wstrb);
      check("sel_wr",    cached ? c_wr    : u_wr,    wr);
      check("sel_size",  cached ? c_size  : u_size,  size);
      check("addr_ok_issue", cpu_addr_ok, 0);
      check("data_ok_issue", cpu_data_ok, 0);
      tick;
      clear_ports;
    end
    if (!same) begin
      if (cached) begin
        c_data_ok = 1'b1; c_rdata = rdata; u_data_ok = spur;
      end else begin
        u_data_ok = 1'b1; u_rdata = rdata; c_data_ok = spur;
      end
      #1;
      check("wait_c_req", c_req, 0);
      check("wait_u_req", u_req, 0);
      check("addr_ok_wait", cpu_addr_ok, 0);
      check("data_ok_wait", cpu_data_ok, 0);
      tick;
      clear_ports;
    end
    #1;
    check("resp_data_ok", cpu_data_ok, 1);
    check("resp_rdata", cpu_rdata, exp_rd);
    check("addr_ok_resp", cpu_addr_ok, 0);
    if (cached) exp_c = exp_c + 4'd1;
    else        exp_u = exp_u + 4'd1;
    tick;
    cpu_req = 1'b0;
    #1;
    check("data_ok_pulse", cpu_data_ok, 0);
    check("rdata_hold", cpu_rdata, exp_rd);
    check("cached_cnt", cached_cnt, exp_c);
    check("uncached_cnt", uncached_cnt, exp_u);
  endtask

  initial begin
    resetn = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_cached = 1'b0; cpu_size = 2'b0;
    cpu_paddr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    c_rdata = '0; u_rdata = '0;
    clear_ports;
    tick;
    tick;
    check("rst_data_ok", cpu_data_ok, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_c_req", c_req, 0);
    check("rst_u_req", u_req, 0);
    check("rst_ccnt", cached_cnt, 0);
    check("rst_ucnt", uncached_cnt, 0);
    check("rst_perr", proto_err, 0);
    resetn = 1'b1;

    do_txn(1'b1, 1'b0, SIZE_WORD, 32'h0000_1000, 32'h0, 4'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    do_txn(1'b0, 1'b1, SIZE_WORD, 32'h1FC0_0000, 32'h1234_5678, 4'hF, 5, 1'b0, 32'hFFFF_FFFF, 1'b0);
    do_txn(1'b1, 1'b0, SIZE_HALF, 32'h0000_2002, 32'h0, 4'h0, 0, 1'b1, 32'hA5A5_A5A5, 1'b0);
    check("perr_clean", proto_err, 0);
    do_txn(1'b1, 1'b0, SIZE_BYTE, 32'h0000_3001, 32'h0, 4'h0, 1, 1'b0, 32'h1122_3344, 1'b1);
    check("perr_wait_spur", proto_err, 1);

    reset_dut;
    check("perr_after_rst", proto_err, 0);
    c_data_ok = 1'b1;
    tick;
    c_data_ok = 1'b0;
    check("perr_idle_spur", proto_err, 1);
    do_txn(1'b1, 1'b0, SIZE_WORD, 32'h0000_4000, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0);
    check("perr_sticky", proto_err, 1);

    // Reset asserted asynchronously in the middle of a cached read's WAIT.
    cpu_req = 1'b1; cpu_cached = 1'b1; cpu_wr = 1'b0; cpu_paddr = 32'h0000_5000;
    tick;
    cpu_req = 1'b0;
    c_addr_ok = 1'b1;
    tick;
    clear_ports;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_c_req", c_req, 0);
    check("arst_data_ok", cpu_data_ok, 0);
    check("arst_rdata", cpu_rdata, 0);
    check("arst_ccnt", cached_cnt, 0);
    check("arst_perr", proto_err, 0);
    tick;
    resetn = 1'b1;
    exp_c = 4'd0;
    exp_u = 4'd0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("no_resp_after_rst", cpu_data_ok, 0);
    end
    do_txn(1'b1, 1'b0, SIZE_WORD, 32'h0000_6000, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b0);
    check("post_rst_ccnt", cached_cnt, 1);

    reset_dut;
    for (int i = 0; i < 17; i++)
      do_txn(1'b0, 1'b0, SIZE_WORD, 32'h8000_0000 + 32'(i * 4), 32'h0, 4'h0, 0,
             1'(i % 2), 32'h0000_0100 + 32'(i), 1'b0);
    check("wrap_ucnt", uncached_cnt, 1);
    check("wrap_ccnt", cached_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
